// File: rtl/tinyqv_mem_arbiter.sv
// Shares the single memory controller port between instruction prefetch and core load/store.
// Data has priority; a burst counter lets a pending fetch win after DATA_BURST data grants.
module tinyqv_mem_arbiter #(
    parameter int ADDR_BITS  = 24,
    parameter int DATA_BURST = 2
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 instr_req,
    input  logic [ADDR_BITS-1:0] instr_addr,
    input  logic                 instr_stop,
    output logic                 instr_ready,
    output logic [15:0]          instr_data,

    input  logic                 data_req,
    input  logic                 data_write,
    input  logic [1:0]           data_size,
    input  logic [ADDR_BITS-1:0] data_addr,
    input  logic [31:0]          data_wdata,
    output logic                 data_ready,
    output logic [31:0]          data_rdata,

    output logic                 mem_start,
    output logic                 mem_write,
    output logic [1:0]           mem_size,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 mem_stop,
    input  logic                 mem_done,
    input  logic [31:0]          mem_rdata
);

    localparam int unsigned    CNT_BITS  = 3;
    localparam logic [CNT_BITS-1:0] BURST_MAX = CNT_BITS'(DATA_BURST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INSTR = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [CNT_BITS-1:0] burst_cnt, burst_cnt_d;
    logic                instr_elig, data_elig;
    logic                grant_instr, grant_data;
    logic                mem_stop_d, instr_ready_d, data_ready_d;

    // Ready outputs mask their own requester so a held request is not granted twice.
    assign instr_elig = instr_req && !instr_ready && !instr_stop;
    assign data_elig  = data_req && !data_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            burst_cnt <= '0;
        end else begin
            state     <= state_d;
            burst_cnt <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d       = state;
        grant_instr   = 1'b0;
        grant_data    = 1'b0;
        mem_stop_d    = 1'b0;
        instr_ready_d = 1'b0;
        data_ready_d  = 1'b0;
        burst_cnt_d   = burst_cnt;

        case (state)
            S_IDLE: begin
                if (data_elig && !(instr_elig && burst_cnt == BURST_MAX)) begin
                    grant_data = 1'b1;
                    state_d    = S_DATA;
                end else if (instr_elig) begin
                    grant_instr = 1'b1;
                    state_d     = S_INSTR;
                end
            end
            S_INSTR: begin
                // A branch abort beats a completion landing in the same cycle.
                if (instr_stop) begin
                    state_d    = S_IDLE;
                    mem_stop_d = !mem_done;
                end else if (mem_done) begin
                    state_d       = S_IDLE;
                    instr_ready_d = 1'b1;
                end
            end
            S_DATA: begin
                if (mem_done) begin
                    state_d      = S_IDLE;
                    data_ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!instr_req || grant_instr) begin
            burst_cnt_d = '0;
        end else if (grant_data && burst_cnt < BURST_MAX) begin
            burst_cnt_d = burst_cnt + CNT_BITS'(1);
        end
    end

    // Registered transaction fields, held until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_start   <= 1'b0;
            mem_stop    <= 1'b0;
            mem_write   <= 1'b0;
            mem_size    <= 2'b00;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            instr_ready <= 1'b0;
            instr_data  <= '0;
            data_ready  <= 1'b0;
            data_rdata  <= '0;
        end else begin
            mem_start   <= grant_instr || grant_data;
            mem_stop    <= mem_stop_d;
            instr_ready <= instr_ready_d;
            data_ready  <= data_ready_d;

            if (grant_instr) begin
                mem_write <= 1'b0;
                mem_size  <= 2'b01;
                mem_addr  <= instr_addr & ~ADDR_BITS'(1);
            end else if (grant_data) begin
                mem_write <= data_write;
                mem_size  <= (data_size == 2'b11) ? 2'b10 : data_size;
                mem_addr  <= data_addr;
                mem_wdata <= data_wdata;
            end

            if (instr_ready_d) instr_data <= mem_rdata[15:0];
            if (data_ready_d)  data_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_tinyqv_mem_arbiter.sv
// Directed bench for tinyqv_mem_arbiter: fetch, burst arbitration, store, abort and reset cases.
module tb_tinyqv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req, instr_stop, instr_ready;
    logic [23:0] instr_addr;
    logic [15:0] instr_data;
    logic        data_req, data_write, data_ready;
    logic [1:0]  data_size;
    logic [23:0] data_addr;
    logic [31:0] data_wdata, data_rdata;
    logic        mem_start, mem_write, mem_stop, mem_done;
    logic [1:0]  mem_size;
    logic [23:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_vec = 0;
    int n_err = 0;
    int n_start = 0, n_stop = 0, n_iready = 0, n_dready = 0;
    int s_start, s_stop, s_iready;
    logic [5:0] exp_kind;

    tinyqv_mem_arbiter #(.ADDR_BITS(24), .DATA_BURST(2)) dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_stop(instr_stop),
        .instr_ready(instr_ready), .instr_data(instr_data),
        .data_req(data_req), .data_write(data_write), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ready(data_ready), .data_rdata(data_rdata),
        .mem_start(mem_start), .mem_write(mem_write), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_stop(mem_stop),
        .mem_done(mem_done), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_start)   n_start++;
            if (mem_stop)    n_stop++;
            if (instr_ready) n_iready++;
            if (data_ready)  n_dready++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_start) seen = 1'b1;
        end
        check({tag, " mem_start seen"}, 32'(seen), 32'd1);
    endtask

    task automatic snapshot();
        @(negedge clk);
        #1;
        s_start  = n_start;
        s_stop   = n_stop;
        s_iready = n_iready;
    endtask

    initial begin
        rst = 1'b1;
        instr_req = 0; instr_addr = '0; instr_stop = 0;
        data_req = 0; data_write = 0; data_size = 2'b00; data_addr = '0; data_wdata = '0;
        mem_done = 0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("reset mem_start", 32'(mem_start), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset instr_ready", 32'(instr_ready), 32'd0);
        rst = 1'b0;

        // Fetch only.
        snapshot();
        instr_req = 1; instr_addr = 24'h000103;
        wait_start("fetch");
        check("fetch mem_addr", 32'(mem_addr), 32'h000102);
        check("fetch mem_size", 32'(mem_size), 32'd1);
        check("fetch mem_write", 32'(mem_write), 32'd0);
        repeat (3) @(negedge clk);
        mem_done = 1; mem_rdata = 32'h0000ABCD;
        @(negedge clk);
        mem_done = 0;
        check("fetch instr_ready", 32'(instr_ready), 32'd1);
        check("fetch instr_data", 32'(instr_data), 32'h0000ABCD);
        instr_req = 0;
        @(negedge clk);
        check("fetch ready one cycle", 32'(instr_ready), 32'd0);
        #1;
        check("fetch start count", 32'(n_start - s_start), 32'd1);
        check("fetch iready count", 32'(n_iready - s_iready), 32'd1);

        // Burst limit: instr_stop in each data_ready cycle holds fetch off without clearing burst_cnt.
        exp_kind = 6'b100100;
        data_req = 1; data_write = 0; data_size = 2'b10; data_addr = 24'h000200;
        instr_req = 1; instr_addr = 24'h000100;
        for (int g = 0; g < 6; g++) begin
            wait_start($sformatf("burst g%0d", g));
            check($sformatf("burst g%0d kind", g), 32'(mem_addr == 24'h000100), 32'(exp_kind[g]));
            if (g == 5) data_req = 0;
            @(negedge clk);
            mem_done = 1; mem_rdata = 32'h00001000 + 32'(g);
            @(negedge clk);
            mem_done = 0;
            if (exp_kind[g]) begin
                check($sformatf("burst g%0d instr_ready", g), 32'(instr_ready), 32'd1);
                if (g == 5) instr_req = 0;
            end else begin
                check($sformatf("burst g%0d data_ready", g), 32'(data_ready), 32'd1);
                instr_stop = 1;
                @(negedge clk);
                instr_stop = 0;
            end
        end

        // Word store.
        @(negedge clk);
        data_req = 1; data_write = 1; data_size = 2'b10; data_addr = 24'h000040; data_wdata = 32'hDEADBEEF;
        wait_start("store");
        check("store mem_write", 32'(mem_write), 32'd1);
        check("store mem_size", 32'(mem_size), 32'd2);
        check("store mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("store mem_addr", 32'(mem_addr), 32'h000040);
        @(negedge clk);
        mem_done = 1;
        @(negedge clk);
        mem_done = 0;
        check("store data_ready", 32'(data_ready), 32'd1);
        data_req = 0; data_write = 0;
        @(negedge clk);
        check("store ready one cycle", 32'(data_ready), 32'd0);

        // Fetch aborted two cycles in, pending load then granted.
        snapshot();
        instr_req = 1; instr_addr = 24'h000300;
        wait_start("abort");
        check("abort fetch addr", 32'(mem_addr), 32'h000300);
        data_req = 1; data_size = 2'b10; data_addr = 24'h000080;
        repeat (2) @(negedge clk);
        instr_stop = 1; instr_req = 0;
        @(negedge clk);
        instr_stop = 0;
        check("abort mem_stop", 32'(mem_stop), 32'd1);
        @(negedge clk);
        check("abort data mem_start", 32'(mem_start), 32'd1);
        check("abort data mem_addr", 32'(mem_addr), 32'h000080);
        check("abort mem_stop one cycle", 32'(mem_stop), 32'd0);
        @(negedge clk);
        mem_done = 1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_done = 0;
        check("abort load ready", 32'(data_ready), 32'd1);
        check("abort load rdata", data_rdata, 32'hCAFEF00D);
        data_req = 0;
        @(negedge clk);
        #1;
        check("abort stop count", 32'(n_stop - s_stop), 32'd1);
        check("abort iready count", 32'(n_iready - s_iready), 32'd0);

        // Stop coincident with mem_done.
        snapshot();
        instr_req = 1; instr_addr = 24'h000400;
        wait_start("coinc");
        @(negedge clk);
        mem_done = 1; mem_rdata = 32'h00001111; instr_stop = 1; instr_req = 0;
        @(negedge clk);
        mem_done = 0; instr_stop = 0;
        check("coinc instr_ready", 32'(instr_ready), 32'd0);
        check("coinc mem_stop", 32'(mem_stop), 32'd0);
        instr_req = 1; instr_addr = 24'h000500;
        @(negedge clk);
        check("coinc idle regrant", 32'(mem_start), 32'd1);
        check("coinc regrant addr", 32'(mem_addr), 32'h000500);
        @(negedge clk);
        mem_done = 1; mem_rdata = 32'h00002222;
        @(negedge clk);
        mem_done = 0;
        check("coinc second ready", 32'(instr_ready), 32'd1);
        check("coinc second data", 32'(instr_data), 32'h00002222);
        instr_req = 0;
        @(negedge clk);
        #1;
        check("coinc iready count", 32'(n_iready - s_iready), 32'd1);
        check("coinc stop count", 32'(n_stop - s_stop), 32'd0);

        // Asynchronous reset mid-DATA, then a stray mem_done.
        data_req = 1; data_size = 2'b00; data_addr = 24'h000044;
        wait_start("rst");
        check("rst byte size", 32'(mem_size), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst async mem_addr", 32'(mem_addr), 32'd0);
        check("rst async mem_wdata", mem_wdata, 32'd0);
        check("rst async data_rdata", data_rdata, 32'd0);
        check("rst async instr_data", 32'(instr_data), 32'd0);
        data_req = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_done = 1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_done = 0;
        check("rst late done ready", 32'(data_ready), 32'd0);
        @(negedge clk);
        check("rst late done ready2", 32'(data_ready), 32'd0);
        check("rst late done rdata", data_rdata, 32'd0);
        check("rst no start", 32'(mem_start), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
